interleaver_frame_scheduler: RTL and testbench
==============================================

Name: interleaver_frame_scheduler

Overview:
Frame-granular round-robin arbiter that shares one pre-interleaver input between NUM_SRC 32-bit AXIS-like sources. A grant always covers one whole interleaver frame of CODEWORD_SIZE_IN_32*NUM_CODEWORDS words, so codeword blocks never mix data from different sources. The block sits directly upstream of the pre-interleaver s_axis port. It adds tlast and a source tag, and provides frame status for the control/status registers.

Parameters:
CODEWORD_SIZE_IN_32, 65, codeword length in 32-bit words; must match the downstream interleaver.
NUM_CODEWORDS, 4, codewords per frame.
NUM_SRC, 2, number of requesting sources, 2..4.
Derived (localparam): FRAME_WORDS = CODEWORD_SIZE_IN_32*NUM_CODEWORDS (260 by default); CW = $clog2(FRAME_WORDS); GW = max(1, $clog2(NUM_SRC)).

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
en  in  1  1 = new grants allowed; 0 = finish the current frame, then hold idle.
s_axis_tdata  in  32*NUM_SRC  source data; source k occupies bits [32k+31:32k].
s_axis_tvalid  in  NUM_SRC  per-source valid; also acts as the request.
s_axis_tready  out  NUM_SRC  per-source ready.
m_axis_tdata  out  32  data to the interleaver.
m_axis_tvalid  out  1  output valid.
m_axis_tready  in  1  interleaver ready.
m_axis_tlast  out  1  high on the last word of a frame.
m_axis_tuser  out  GW  ID of the granted source.
busy  out  1  high while in XFER.
frame_done  out  1  one-cycle pulse after each completed frame.
frame_cnt  out  16  completed-frame count; wraps at 0xFFFF->0.

Behaviour:
- FSM has two states: IDLE and XFER. Registered state: grant[GW-1:0], last_grant, word_cnt[CW-1:0], frame_done, frame_cnt.
- Reset values: state IDLE, word_cnt 0, grant 0, last_grant NUM_SRC-1 (so source 0 wins first), frame_cnt 0, frame_done 0.
- After reset, outputs are: s_axis_tready all 0, m_axis_tvalid 0, m_axis_tlast 0, busy 0, m_axis_tuser 0, m_axis_tdata 0.
- IDLE:
  - If en=1 and any s_axis_tvalid bit is high, grant is set to the first requesting index found by searching from last_grant+1 upward, wrapping modulo NUM_SRC. State moves to XFER on the next clock.
  - Arbitration takes 1 cycle. While in IDLE, all s_axis_tready are 0 and m_axis_tvalid is 0.
- XFER (pass-through, zero latency):
  - m_axis_tdata = s_axis_tdata[grant], m_axis_tvalid = s_axis_tvalid[grant].
  - s_axis_tready[grant] = m_axis_tready; every other s_axis_tready bit is 0.
  - m_axis_tuser = grant and busy = 1.
  - m_axis_tlast = (word_cnt == FRAME_WORDS-1) && m_axis_tvalid.
- A handshake is m_axis_tvalid && m_axis_tready.
  - On a handshake with word_cnt < FRAME_WORDS-1, word_cnt increments.
  - On a handshake with word_cnt == FRAME_WORDS-1: word_cnt goes to 0, last_grant takes grant, frame_cnt increments, frame_done = 1 for the next cycle, state returns to IDLE.
- Frame-to-frame gap is exactly 1 idle cycle (the IDLE arbitration cycle).
- Stall by the granted source (tvalid low mid-frame): no timeout. Grant is held and word_cnt frozen; other sources stay blocked.
- Back-pressure (m_axis_tready low): word_cnt frozen and the source sees tready 0. Data is not registered, so no data loss is possible.
- en dropping mid-frame has no effect until tlast has been transferred; after that the FSM stays in IDLE while en=0.
- A source deasserting tvalid while in IDLE simply drops its request; there is no sticky request.
- A request in the same cycle as frame completion is arbitrated in the following IDLE cycle.
- rst mid-frame: everything returns to reset values on the next clock and the partial frame is abandoned. The downstream interleaver must be reset together with this block.
- frame_done and frame_cnt update on the same clock edge.

Test Plan:
- Only source 0 valid, en=1, m_axis_tready=1, data 0..259: first output 1 cycle after tvalid; m_axis_tuser=0; tlast only on data 259; frame_done pulses once the cycle after; frame_cnt=1; busy low the cycle after tlast.
- Both sources continuously valid for 3 frames: tuser sequence 0,1,0; each frame exactly 260 words; exactly 1 idle cycle between frames; the non-granted source's tready is never high.
- Source 1 valid, 50% random m_axis_tready: output stream equals the source stream in order; tlast on the 260th handshake; no duplicate or dropped words.
- Source 0 drops tvalid for 20 cycles after word 100 while source 1 is valid: grant stays 0; source 1 tready stays 0; the frame completes with 260 words from source 0 only, then source 1 is granted.
- en taken to 0 at word 10, with both sources valid: the current frame completes; no new grant while en=0; re-asserting en grants the next source in round-robin order.
- rst pulsed at word 130: the next cycle shows all readies 0, tvalid 0, frame_cnt 0. The next frame goes to source 0, starting again at word_cnt 0.

Source files
------------

// File: rtl/interleaver_frame_scheduler.sv
// Frame-granular round-robin arbiter feeding the pre-interleaver input.
// A grant covers one whole frame of CODEWORD_SIZE_IN_32*NUM_CODEWORDS words; data is passed through unregistered.
module interleaver_frame_scheduler #(
  parameter int unsigned CODEWORD_SIZE_IN_32 = 65,
  parameter int unsigned NUM_CODEWORDS       = 4,
  parameter int unsigned NUM_SRC             = 2,
  localparam int unsigned FRAME_WORDS = CODEWORD_SIZE_IN_32 * NUM_CODEWORDS,
  localparam int unsigned CW          = $clog2(FRAME_WORDS),
  localparam int unsigned GW          = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [32*NUM_SRC-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]    s_axis_tvalid,
  output logic [NUM_SRC-1:0]    s_axis_tready,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [GW-1:0]         m_axis_tuser,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state, state_d;
  logic [GW-1:0]   grant, grant_d;
  logic [GW-1:0]   last_grant, last_grant_d;
  logic [CW-1:0]   word_cnt, word_cnt_d;
  logic            frame_done_d;
  logic [15:0]     frame_cnt_d;
  logic [GW-1:0]   pick, idx;
  logic            pick_vld;
  logic            at_last, hs;

  // Round-robin search starting just after the last granted source
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int unsigned i = NUM_SRC; i >= 1; i--) begin
      idx = GW'((32'(last_grant) + i) % NUM_SRC);
      if (s_axis_tvalid[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_SRC - 1);
      word_cnt   <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      last_grant <= last_grant_d;
      word_cnt   <= word_cnt_d;
      frame_done <= frame_done_d;
      frame_cnt  <= frame_cnt_d;
    end
  end

  // Pass-through muxing, frame counting and next state
  always_comb begin
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    busy          = 1'b0;
    state_d       = state;
    grant_d       = grant;
    last_grant_d  = last_grant;
    word_cnt_d    = word_cnt;
    frame_done_d  = 1'b0;
    frame_cnt_d   = frame_cnt;
    at_last       = (word_cnt == CW'(FRAME_WORDS - 1));
    hs            = 1'b0;

    if (state == XFER) begin
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        if (GW'(k) == grant) begin
          m_axis_tdata  = s_axis_tdata[32*k +: 32];
          m_axis_tvalid = s_axis_tvalid[k];
        end
      end
      s_axis_tready[grant] = m_axis_tready;
      m_axis_tuser         = grant;
      busy                 = 1'b1;
      m_axis_tlast         = at_last && m_axis_tvalid;
      hs                   = m_axis_tvalid && m_axis_tready;

      if (hs) begin
        if (at_last) begin
          word_cnt_d   = '0;
          last_grant_d = grant;
          frame_cnt_d  = frame_cnt + 16'd1;
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          word_cnt_d = word_cnt + CW'(1);
        end
      end
    end else if (en && pick_vld) begin
      grant_d = pick;
      state_d = XFER;
    end
  end

endmodule

// File: tb/tb_interleaver_frame_scheduler.sv
// Directed bench for interleaver_frame_scheduler: two sources, 260-word frames.
// Each cycle is sampled at the falling edge; protocol rules are tallied and checked per scenario.
module tb_interleaver_frame_scheduler;

  localparam int FRAME_WORDS = 260;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [63:0] s_axis_tdata;
  logic [1:0]  s_axis_tvalid;
  logic [1:0]  s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [0:0]  m_axis_tuser;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;

  interleaver_frame_scheduler #(
    .CODEWORD_SIZE_IN_32(65),
    .NUM_CODEWORDS      (4),
    .NUM_SRC            (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Source k emits word n as {k, n} so origin and order are both visible
  int ptr [2];
  function automatic logic [31:0] word(input int k, input int n);
    return 32'((k << 16) | n);
  endfunction
  assign s_axis_tdata = {word(1, ptr[1]), word(0, ptr[0])};

  // Bench-side reference state
  logic [15:0] fc_model;
  logic        prev_done;
  int          fw;
  int          frames[$];
  int          gaps[$];
  bit          gap_on;
  int          gap_n;
  int          proto_err, data_err;
  bit          rand_rdy;

  logic        s_busy, s_done, s_valid, s_last;
  logic [0:0]  s_tuser;
  logic [31:0] s_tdata;
  logic [1:0]  s_tready;
  logic [15:0] s_fcnt;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int last_frame();
    return (frames.size() == 0) ? -1 : frames[frames.size()-1];
  endfunction

  // One clock: sample and audit at negedge, update reference at posedge, then inputs may change
  task automatic cyc();
    logic       hs, lst;
    logic [0:0] u;
    logic [1:0] exp_rdy;
    logic       exp_v, exp_last;
    @(negedge clk);
    s_busy = busy; s_done = frame_done; s_valid = m_axis_tvalid; s_last = m_axis_tlast;
    s_tuser = m_axis_tuser; s_tdata = m_axis_tdata; s_tready = s_axis_tready; s_fcnt = frame_cnt;
    u   = m_axis_tuser;
    hs  = m_axis_tvalid && m_axis_tready;
    lst = m_axis_tlast;
    exp_rdy  = busy ? (2'(m_axis_tready) << u) : 2'b00;
    exp_v    = busy ? s_axis_tvalid[u] : 1'b0;
    exp_last = busy && (fw == FRAME_WORDS - 1) && m_axis_tvalid;
    if (s_axis_tready !== exp_rdy)  proto_err++;
    if (m_axis_tvalid !== exp_v)    proto_err++;
    if (m_axis_tlast  !== exp_last) proto_err++;
    if (frame_cnt  !== fc_model)    proto_err++;
    if (frame_done !== prev_done)   proto_err++;
    if (busy && hs && m_axis_tdata !== word(int'(u), ptr[u])) data_err++;
    if (gap_on) begin
      if (!busy) gap_n++;
      else begin gaps.push_back(gap_n); gap_on = 1'b0; end
    end
    @(posedge clk);
    if (rst) begin
      fc_model = '0; fw = 0; prev_done = 1'b0; gap_on = 1'b0;
    end else begin
      prev_done = hs && lst;
      if (hs) begin
        ptr[u]++;
        if (lst) begin
          fw = 0; fc_model++; frames.push_back(int'(u)); gap_on = 1'b1; gap_n = 0;
        end else begin
          fw++;
        end
      end
    end
    #1;
    if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_frames(input string tag, input int n, input int budget);
    int target = frames.size() + n;
    int c = 0;
    while (frames.size() < target && c < budget) begin cyc(); c++; end
    check({tag, "_frames_timeout"}, frames.size() >= target, 1);
  endtask

  task automatic run_until_ptr(input string tag, input int k, input int val, input int budget);
    int c = 0;
    while (ptr[k] < val && c < budget) begin cyc(); c++; end
    check({tag, "_words_timeout"}, ptr[k] >= val, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1; s_axis_tvalid = 2'b00;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic audit(input string tag);
    check({tag, "_proto_err"}, proto_err, 0);
    check({tag, "_data_err"}, data_err, 0);
    proto_err = 0; data_err = 0;
  endtask

  initial begin
    int stall_err, idle_err;
    rst = 1'b1; en = 1'b0; s_axis_tvalid = 2'b00; m_axis_tready = 1'b0;
    ptr[0] = 0; ptr[1] = 0; fc_model = '0; prev_done = 1'b0; fw = 0;
    gap_on = 1'b0; gap_n = 0; proto_err = 0; data_err = 0; rand_rdy = 1'b0;

    // Reset state
    do_reset();
    cyc();
    check("rst_tready", s_tready, 0);
    check("rst_tvalid", s_valid, 0);
    check("rst_tlast", s_last, 0);
    check("rst_busy", s_busy, 0);
    check("rst_tuser", s_tuser, 0);
    check("rst_tdata", s_tdata, 0);
    check("rst_fcnt", s_fcnt, 0);
    check("rst_done", s_done, 0);
    proto_err = 0;

    // Single source 0 frame
    en = 1'b1; m_axis_tready = 1'b1; s_axis_tvalid = 2'b01;
    cyc();
    check("t1_arb_no_valid", s_valid, 0);
    cyc();
    check("t1_first_valid", s_valid, 1);
    check("t1_first_tuser", s_tuser, 0);
    check("t1_first_data", s_tdata, 0);
    wait_frames("t1", 1, 400);
    check("t1_frame_src", last_frame(), 0);
    check("t1_words", ptr[0], 260);
    s_axis_tvalid = 2'b00;
    cyc();
    check("t1_busy_after", s_busy, 0);
    check("t1_done_pulse", s_done, 1);
    check("t1_fcnt", s_fcnt, 1);
    cyc();
    check("t1_done_cleared", s_done, 0);
    audit("t1");

    // Both sources, three frames of round robin
    do_reset();
    ptr[0] = 0; ptr[1] = 0; frames.delete(); gaps.delete();
    s_axis_tvalid = 2'b11;
    wait_frames("t2", 3, 1200);
    check("t2_frame0_src", frames.size() > 0 ? frames[0] : -1, 0);
    check("t2_frame1_src", frames.size() > 1 ? frames[1] : -1, 1);
    check("t2_frame2_src", frames.size() > 2 ? frames[2] : -1, 0);
    check("t2_gap_count", gaps.size(), 2);
    check("t2_gap0", gaps.size() > 0 ? gaps[0] : -1, 1);
    check("t2_gap1", gaps.size() > 1 ? gaps[1] : -1, 1);
    check("t2_src0_words", ptr[0], 520);
    check("t2_src1_words", ptr[1], 260);
    audit("t2");

    // Source 1 alone under random back-pressure
    s_axis_tvalid = 2'b10; ptr[1] = 0; rand_rdy = 1'b1;
    wait_frames("t3", 1, 2000);
    rand_rdy = 1'b0; m_axis_tready = 1'b1;
    check("t3_frame_src", last_frame(), 1);
    check("t3_words", ptr[1], 260);
    audit("t3");

    // Source 0 stalls mid-frame while source 1 requests
    ptr[0] = 0; ptr[1] = 0; s_axis_tvalid = 2'b11;
    run_until_ptr("t4", 0, 101, 300);
    s_axis_tvalid = 2'b10;
    stall_err = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (!s_busy || s_tuser !== 1'b0) stall_err++;
    end
    check("t4_grant_held", stall_err, 0);
    check("t4_frozen_words", ptr[0], 101);
    s_axis_tvalid = 2'b11;
    wait_frames("t4", 1, 400);
    check("t4_frame_src", last_frame(), 0);
    check("t4_src0_words", ptr[0], 260);
    check("t4_src1_blocked", ptr[1], 0);
    cyc(); cyc();
    check("t4_next_busy", s_busy, 1);
    check("t4_next_src", s_tuser, 1);
    audit("t4");

    // en dropped at word 10
    do_reset();
    ptr[0] = 0; ptr[1] = 0; s_axis_tvalid = 2'b11;
    run_until_ptr("t5", 0, 10, 100);
    en = 1'b0;
    wait_frames("t5", 1, 400);
    check("t5_frame_src", last_frame(), 0);
    check("t5_words", ptr[0], 260);
    idle_err = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (s_busy) idle_err++;
    end
    check("t5_held_idle", idle_err, 0);
    check("t5_src1_untouched", ptr[1], 0);
    en = 1'b1;
    cyc(); cyc();
    check("t5_regrant_busy", s_busy, 1);
    check("t5_regrant_src", s_tuser, 1);
    audit("t5");

    // Reset in the middle of a frame from source 1
    run_until_ptr("t6", 1, 130, 300);
    check("t6_fcnt_before", s_fcnt, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    check("t6_tready", s_tready, 0);
    check("t6_tvalid", s_valid, 0);
    check("t6_fcnt", s_fcnt, 0);
    check("t6_busy", s_busy, 0);
    ptr[0] = 0;
    wait_frames("t6", 1, 400);
    check("t6_frame_src", last_frame(), 0);
    check("t6_words", ptr[0], 260);
    cyc();
    check("t6_fcnt_after", s_fcnt, 1);
    check("t6_done", s_done, 1);
    audit("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
